// File: rtl/pipe_ctrl_sb_if.sv
// Hazard-control bundle between the pipeline and pipe_ctrl_sb: ID/EX/MEM decode state in,
// stall/flush/forward selects and long-op scoreboard state out.
interface pipe_ctrl_sb_if #(
    parameter int unsigned AW = 5
) ();
    // ID stage
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic          readsRs;
    logic          readsRt;
    logic          regWrite;
    logic          isStore;
    logic          isLongOp;
    logic          branch;
    logic          jump;
    logic          brTaken;
    // EX / MEM stages
    logic [AW-1:0] ex_rd;
    logic          ex_regWrite;
    logic          ex_isLoad;
    logic [AW-1:0] mem_rd;
    logic          mem_regWrite;
    // Controller outputs
    logic          stall;
    logic          flush;
    logic          flowChange;
    logic [1:0]    id_forwardA;
    logic [1:0]    id_forwardB;
    logic          id_ldstBypass;
    logic          lop_busy;
    logic          lop_wb;
    logic [AW-1:0] lop_wb_rd;

    modport master (
        output rs, rt, rd, readsRs, readsRt, regWrite, isStore, isLongOp,
        output branch, jump, brTaken,
        output ex_rd, ex_regWrite, ex_isLoad, mem_rd, mem_regWrite,
        input  stall, flush, flowChange, id_forwardA, id_forwardB, id_ldstBypass,
        input  lop_busy, lop_wb, lop_wb_rd
    );

    modport slave (
        input  rs, rt, rd, readsRs, readsRt, regWrite, isStore, isLongOp,
        input  branch, jump, brTaken,
        input  ex_rd, ex_regWrite, ex_isLoad, mem_rd, mem_regWrite,
        output stall, flush, flowChange, id_forwardA, id_forwardB, id_ldstBypass,
        output lop_busy, lop_wb, lop_wb_rd
    );
endinterface

// File: rtl/pipe_ctrl_sb.sv
// In-order pipeline hazard controller: load-use / branch / long-op stalls, EX-MEM-WB and
// long-op forwarding selects, and a single-entry scoreboard for the fixed-latency mul/div unit.
module pipe_ctrl_sb #(
    parameter int unsigned AW      = 5,
    parameter int unsigned LOP_LAT = 4
) (
    input logic           clk,
    input logic           reset,
    pipe_ctrl_sb_if.slave bus
);

    localparam int unsigned   CW      = $clog2(LOP_LAT + 1);
    localparam logic [CW-1:0] CntLoad = CW'(LOP_LAT);
    localparam logic [CW-1:0] CntLast = CW'(1);

    typedef enum logic [0:0] {StIdle, StBusy} lopState_e;

    lopState_e     stateQ, stateD;
    logic [CW-1:0] cntQ, cntD;
    logic [AW-1:0] lopRdQ, lopRdD;

    function automatic logic regHit(input logic en, input logic [AW-1:0] x,
                                    input logic [AW-1:0] r);
        return en && (x != '0) && (x == r);
    endfunction

    function automatic logic [1:0] fwdSel(input logic [AW-1:0] r,
                                          input logic exWr, input logic [AW-1:0] exRd,
                                          input logic memWr, input logic [AW-1:0] memRd,
                                          input logic wb, input logic [AW-1:0] wbRd);
        logic [1:0] sel;
        sel = 2'b00;
        if (regHit(exWr, exRd, r)) begin
            sel = 2'b10;
        end else if (regHit(memWr, memRd, r)) begin
            sel = 2'b01;
        end else if (regHit(wb, wbRd, r)) begin
            sel = 2'b11;
        end
        return sel;
    endfunction

    logic sbLive, lastCycle, hazWin, wbLive;
    logic exA, exB, memA, memB, lopA, lopB;
    logic loadUse, brStall, lopStall, stall, issue;

    // Scoreboard terms are masked while reset is held so stale state cannot stall or forward.
    always_comb begin
        sbLive    = (stateQ == StBusy) && !reset;
        lastCycle = (cntQ == CntLast);
        hazWin    = sbLive && !lastCycle;
        wbLive    = sbLive && lastCycle;

        exA  = regHit(bus.readsRs, bus.ex_rd, bus.rs);
        exB  = regHit(bus.readsRt, bus.ex_rd, bus.rt);
        memA = regHit(bus.readsRs, bus.mem_rd, bus.rs);
        memB = regHit(bus.readsRt, bus.mem_rd, bus.rt);
        lopA = regHit(bus.readsRs, lopRdQ, bus.rs);
        lopB = regHit(bus.readsRt, lopRdQ, bus.rt);

        // Store data that depends on a load is served by the ld/st bypass instead of stalling.
        loadUse  = bus.ex_isLoad && (exA || (exB && !bus.isStore));
        brStall  = bus.branch && ((bus.ex_regWrite && (exA || exB)) ||
                                  (bus.mem_regWrite && (memA || memB)));
        lopStall = hazWin && (lopA || lopB || bus.isLongOp ||
                              (bus.regWrite && (bus.rd == lopRdQ) && (lopRdQ != '0)));

        stall = loadUse || brStall || lopStall;
        issue = bus.isLongOp && !stall;
    end

    assign bus.stall         = stall;
    assign bus.flush         = (bus.branch && bus.brTaken && !stall) || bus.jump;
    assign bus.flowChange    = bus.flush;
    assign bus.id_ldstBypass = bus.isStore && bus.ex_isLoad && (bus.ex_rd != '0) &&
                               (bus.ex_rd == bus.rt);
    assign bus.id_forwardA   = fwdSel(bus.rs, bus.ex_regWrite, bus.ex_rd,
                                      bus.mem_regWrite, bus.mem_rd, wbLive, lopRdQ);
    assign bus.id_forwardB   = fwdSel(bus.rt, bus.ex_regWrite, bus.ex_rd,
                                      bus.mem_regWrite, bus.mem_rd, wbLive, lopRdQ);
    assign bus.lop_busy      = (stateQ == StBusy);
    assign bus.lop_wb        = wbLive;
    assign bus.lop_wb_rd     = lopRdQ;

    // An issue in the write-back cycle reloads the unit without an idle gap.
    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        lopRdD = lopRdQ;
        if (issue) begin
            stateD = StBusy;
            cntD   = CntLoad;
            lopRdD = bus.rd;
        end else if (stateQ == StBusy) begin
            if (lastCycle) begin
                stateD = StIdle;
                cntD   = '0;
            end else begin
                cntD = cntQ - CntLast;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= StIdle;
            cntQ   <= '0;
            lopRdQ <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            lopRdQ <= lopRdD;
        end
    end

    aCntNonZero : assert property (@(posedge clk) disable iff (reset)
                                   (stateQ == StBusy) |-> (cntQ != '0));
    aCntBounded : assert property (@(posedge clk) disable iff (reset) cntQ <= CntLoad);

endmodule

// File: tb/tb_pipe_ctrl_sb.sv
// Randomised bench for pipe_ctrl_sb against a cycle-indexed reference model, plus directed
// long-op, load/store bypass and branch scenarios.
module tb_pipe_ctrl_sb;
    localparam int unsigned AW  = 5;
    localparam int          LAT = 4;

    logic clk;
    logic reset;

    pipe_ctrl_sb_if #(.AW(AW)) bus ();

    pipe_ctrl_sb #(.AW(AW), .LOP_LAT(LAT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            issueCycle = -1;  // cycle the live long op was accepted, -1 if none
    logic [AW-1:0] lopRd = '0;
    logic          expStall;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic hit(input logic en, input logic [AW-1:0] x, input logic [AW-1:0] r);
        return en && (x != 0) && (x == r);
    endfunction

    function automatic logic [1:0] expFwd(input logic [AW-1:0] r, input logic wb);
        if (bus.ex_regWrite && bus.ex_rd != 0 && bus.ex_rd == r) return 2'b10;
        if (bus.mem_regWrite && bus.mem_rd != 0 && bus.mem_rd == r) return 2'b01;
        if (wb && lopRd != 0 && lopRd == r) return 2'b11;
        return 2'b00;
    endfunction

    task automatic setIdle();
        bus.rs = '0; bus.rt = '0; bus.rd = '0;
        bus.readsRs = 0; bus.readsRt = 0; bus.regWrite = 0; bus.isStore = 0; bus.isLongOp = 0;
        bus.branch = 0; bus.jump = 0; bus.brTaken = 0;
        bus.ex_rd = '0; bus.ex_regWrite = 0; bus.ex_isLoad = 0;
        bus.mem_rd = '0; bus.mem_regWrite = 0;
    endtask

    task automatic drvRandom();
        bus.rs = AW'($urandom_range(0, 9));
        bus.rt = AW'($urandom_range(0, 9));
        bus.rd = AW'($urandom_range(0, 9));
        bus.ex_rd = AW'($urandom_range(0, 9));
        bus.mem_rd = AW'($urandom_range(0, 9));
        bus.readsRs = 1'($urandom_range(0, 1));
        bus.readsRt = 1'($urandom_range(0, 1));
        bus.regWrite = 1'($urandom_range(0, 1));
        bus.isStore = 1'($urandom_range(0, 1));
        bus.isLongOp = ($urandom_range(0, 3) == 0);
        bus.branch = ($urandom_range(0, 3) == 0);
        bus.brTaken = 1'($urandom_range(0, 1));
        bus.jump = ($urandom_range(0, 7) == 0);
        bus.ex_regWrite = 1'($urandom_range(0, 1));
        bus.ex_isLoad = 1'($urandom_range(0, 1));
        bus.mem_regWrite = 1'($urandom_range(0, 1));
        reset = ($urandom_range(0, 31) == 0);
    endtask

    // Inputs are already applied; let them settle, then compare every output to the model.
    task automatic evalCycle();
        int   age;
        logic busy, win, wb, lu, br, sb, expFlush, expBypass;
        #2;
        age  = cyc - issueCycle;
        busy = (issueCycle >= 0) && (age >= 1) && (age <= LAT);
        win  = busy && !reset && (age < LAT);
        wb   = busy && !reset && (age == LAT);
        lu   = bus.ex_isLoad && (hit(bus.readsRs, bus.ex_rd, bus.rs) ||
                                 (hit(bus.readsRt, bus.ex_rd, bus.rt) && !bus.isStore));
        br   = bus.branch &&
               ((bus.ex_regWrite && (hit(bus.readsRs, bus.ex_rd, bus.rs) ||
                                     hit(bus.readsRt, bus.ex_rd, bus.rt))) ||
                (bus.mem_regWrite && (hit(bus.readsRs, bus.mem_rd, bus.rs) ||
                                      hit(bus.readsRt, bus.mem_rd, bus.rt))));
        sb   = win && (hit(bus.readsRs, lopRd, bus.rs) || hit(bus.readsRt, lopRd, bus.rt) ||
                       (bus.regWrite && bus.rd == lopRd && lopRd != 0) || bus.isLongOp);
        expStall  = lu || br || sb;
        expFlush  = (bus.branch && bus.brTaken && !expStall) || bus.jump;
        expBypass = bus.isStore && bus.ex_isLoad && bus.ex_rd != 0 && bus.ex_rd == bus.rt;
        checkEq("stall", 32'(bus.stall), 32'(expStall));
        checkEq("flush", 32'(bus.flush), 32'(expFlush));
        checkEq("flowChange", 32'(bus.flowChange), 32'(expFlush));
        checkEq("fwdA", 32'(bus.id_forwardA), 32'(expFwd(bus.rs, wb)));
        checkEq("fwdB", 32'(bus.id_forwardB), 32'(expFwd(bus.rt, wb)));
        checkEq("ldstBypass", 32'(bus.id_ldstBypass), 32'(expBypass));
        checkEq("lop_busy", 32'(bus.lop_busy), 32'(busy));
        checkEq("lop_wb", 32'(bus.lop_wb), 32'(wb));
        checkEq("lop_wb_rd", 32'(bus.lop_wb_rd), 32'(lopRd));
    endtask

    task automatic advance();
        if (reset) begin
            issueCycle = -1;
            lopRd      = '0;
        end else if (bus.isLongOp && !expStall) begin
            issueCycle = cyc;
            lopRd      = bus.rd;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic longOp(input logic [AW-1:0] dst);
        setIdle();
        bus.isLongOp = 1; bus.regWrite = 1; bus.rd = dst;
    endtask

    initial begin
        reset = 1;
        setIdle();
        @(posedge clk);
        #1;
        evalCycle();
        advance();
        reset = 0;

        // mul r8, then a dependent add that waits for the write-back forward
        longOp(5'd8); evalCycle(); checkEq("mul_issue", 32'(bus.stall), 0); advance();
        setIdle(); evalCycle(); checkEq("mul_busy1", 32'(bus.lop_busy), 1); advance();
        for (int c = 2; c < 4; c++) begin
            setIdle(); bus.readsRs = 1; bus.rs = 8; bus.regWrite = 1; bus.rd = 10;
            evalCycle();
            checkEq("raw_stall", 32'(bus.stall), 1);
            checkEq("raw_nowb", 32'(bus.lop_wb), 0);
            advance();
        end
        setIdle(); bus.readsRs = 1; bus.rs = 8; bus.regWrite = 1; bus.rd = 10;
        evalCycle();
        checkEq("wb_nostall", 32'(bus.stall), 0);
        checkEq("wb_fwdA", 32'(bus.id_forwardA), 32'(2'b11));
        checkEq("wb_pulse", 32'(bus.lop_wb), 1);
        checkEq("wb_rd", 32'(bus.lop_wb_rd), 8);
        advance();
        setIdle(); evalCycle(); checkEq("drained", 32'(bus.lop_busy), 0); advance();

        // Structural stall, back-to-back issue in the write-back cycle, reset discards op
        longOp(5'd8); evalCycle(); advance();
        setIdle(); evalCycle(); advance();
        for (int c = 2; c < 4; c++) begin
            longOp(5'd9); evalCycle(); checkEq("struct_stall", 32'(bus.stall), 1); advance();
        end
        longOp(5'd9); evalCycle();
        checkEq("b2b_issue", 32'(bus.stall), 0);
        checkEq("b2b_wb", 32'(bus.lop_wb), 1);
        advance();
        setIdle(); evalCycle();
        checkEq("b2b_busy", 32'(bus.lop_busy), 1);
        checkEq("b2b_rd", 32'(bus.lop_wb_rd), 9);
        advance();
        longOp(5'd9); reset = 1; evalCycle(); checkEq("rst_nostall", 32'(bus.stall), 0); advance();
        reset = 0;
        for (int c = 7; c < 10; c++) begin
            setIdle(); evalCycle();
            checkEq("rst_idle", 32'(bus.lop_busy), 0);
            checkEq("rst_nowb", 32'(bus.lop_wb), 0);
            advance();
        end

        // Load followed by dependent store (bypass) and dependent add (stall)
        setIdle(); bus.ex_isLoad = 1; bus.ex_regWrite = 1; bus.ex_rd = 5;
        bus.isStore = 1; bus.readsRs = 1; bus.readsRt = 1; bus.rs = 6; bus.rt = 5;
        evalCycle();
        checkEq("sw_nostall", 32'(bus.stall), 0);
        checkEq("sw_bypass", 32'(bus.id_ldstBypass), 1);
        advance();
        setIdle(); bus.ex_isLoad = 1; bus.ex_regWrite = 1; bus.ex_rd = 5;
        bus.readsRs = 1; bus.rs = 5; bus.regWrite = 1; bus.rd = 7;
        evalCycle(); checkEq("loaduse_stall", 32'(bus.stall), 1); advance();

        // Taken branch with and without a MEM-stage dependency
        setIdle(); bus.branch = 1; bus.brTaken = 1; bus.readsRs = 1; bus.rs = 3;
        bus.mem_regWrite = 1; bus.mem_rd = 3;
        evalCycle();
        checkEq("br_stall", 32'(bus.stall), 1);
        checkEq("br_noflush", 32'(bus.flush), 0);
        advance();
        setIdle(); bus.branch = 1; bus.brTaken = 1; bus.readsRs = 1; bus.rs = 3;
        bus.mem_regWrite = 1; bus.mem_rd = 0;
        evalCycle();
        checkEq("br_go", 32'(bus.stall), 0);
        checkEq("br_flush", 32'(bus.flush), 1);
        advance();

        for (int n = 0; n < 600; n++) begin
            drvRandom();
            evalCycle();
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_sb.md
PIPE_CTRL_SB -- requirements
Module: pipe_ctrl_sb

Interface
REQ-001 Parameter AW, default 5, register-address width; register 0 is hardwired zero.
REQ-002 Parameter LOP_LAT, default 4, long-op (mul/div) latency in cycles; legal range 2..15.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rs, rt, rd  in  AW each  ID-stage source A, source B, destination.
REQ-006 readsRs, readsRt, regWrite, isStore, isLongOp  in  1 each  ID-stage decode flags; isLongOp marks an op that writes rd after LOP_LAT cycles.
REQ-007 branch, jump, brTaken  in  1 each  ID-stage flow-control flags.
REQ-008 ex_rd  in  AW;  ex_regWrite, ex_isLoad  in  1 each  EX-stage state.
REQ-009 mem_rd  in  AW;  mem_regWrite  in  1  MEM-stage state.
REQ-010 stall, flush, flowChange  out  1 each  pipeline control; flowChange equals flush.
REQ-011 id_forwardA, id_forwardB  out  2 each  operand select: 00 regfile, 10 EX result, 01 WB value, 11 long-op result.
REQ-012 id_ldstBypass  out  1  forward just-loaded value to store data.
REQ-013 lop_busy  out  1;  lop_wb  out  1;  lop_wb_rd  out  AW  long-op scoreboard state and one-cycle write-back strobe.

Function
REQ-014 Match terms: mA(x) = readsRs & x!=0 & x==rs; mB(x) = readsRt & x!=0 & x==rt.
REQ-015 id_forwardA priority: 10 if ex_regWrite & ex_rd!=0 & ex_rd==rs; else 01 if mem_regWrite & mem_rd!=0 & mem_rd==rs; else 11 if lop_wb & lop_wb_rd!=0 & lop_wb_rd==rs; else 00; id_forwardB identical on rt.
REQ-016 id_ldstBypass = isStore & ex_isLoad & ex_rd!=0 & ex_rd==rt.
REQ-017 Load-use stall: ex_isLoad & (mA(ex_rd) | (mB(ex_rd) & ~isStore)); store-data dependency on a load does not stall (bypass covers it).
REQ-018 Branch stall: branch & ((ex_regWrite & (mA(ex_rd)|mB(ex_rd))) | (mem_regWrite & (mA(mem_rd)|mB(mem_rd)))).
REQ-019 Scoreboard hazard window H = lop_busy & ~lop_wb.
REQ-020 Long-op stalls during H: RAW mA(lop_rd)|mB(lop_rd); WAW regWrite & rd==lop_rd & lop_rd!=0; structural isLongOp.
REQ-021 stall = OR of REQ-017, REQ-018, REQ-020 terms; purely combinational.
REQ-022 flush = (branch & brTaken & ~stall) | jump.
REQ-023 Issue = isLongOp & ~stall; on issue edge: lop_busy<=1, cnt<=LOP_LAT, lop_rd<=rd.
REQ-024 While lop_busy and no issue: cnt decrements each cycle; when cnt==1 it clears lop_busy on the next edge.
REQ-025 lop_wb = lop_busy & cnt==1; lop_wb_rd = lop_rd; issue at cycle T gives lop_busy in T+1..T+LOP_LAT and lop_wb exactly in cycle T+LOP_LAT.
REQ-026 Back-to-back: issue in the lop_wb cycle is allowed; it reloads cnt and lop_rd, and lop_busy stays 1 without a gap.
REQ-027 Counter width = clog2(LOP_LAT+1); no wrap; cnt never decrements below 1 while busy.
REQ-028 Long op with rd==0 still occupies the unit; lop_wb pulses but never forwards (11 suppressed).

Reset
REQ-029 On reset edge: lop_busy=0, cnt=0, lop_rd=0; thus lop_wb=0, lop_wb_rd=0.
REQ-030 Reset overrides a simultaneous issue; an in-flight long op is discarded with no lop_wb pulse.
REQ-031 Combinational outputs follow inputs during reset, with scoreboard terms inactive.

Verification
REQ-032 LOP_LAT=4, issue mul rd=8 at cycle 0 -> lop_busy cycles 1-4, lop_wb=1 with lop_wb_rd=8 only in cycle 4.
REQ-033 Cycle 2 ID add reads rs=8 -> stall=1 cycles 2-3; cycle 4 stall=0, id_forwardA=11.
REQ-034 ex_isLoad, ex_rd=5; ID sw rt=5 rs=6 -> stall=0, id_ldstBypass=1; ID add rs=5 -> stall=1.
REQ-035 branch, brTaken, rs=3, mem_regWrite, mem_rd=3 -> stall=1, flush=0; same with mem_rd=0 -> stall=0, flush=1.
REQ-036 Second isLongOp in cycle 2 -> stall until cycle 4; issue in cycle 4, lop_wb next in cycle 8; reset asserted in cycle 6 -> lop_busy=0 in cycle 7, no lop_wb.
